fft_dmem_arbiter: RTL and testbench

- Shares the single-port 16-bit FFT sample memory (dmem) between two requesters: M0 = MCU core load/store path, M1 = FFT butterfly engine.
- Issues at most one memory access per cycle.
- Arbitration is round-robin, with an optional locked burst that is capped so neither side starves.
- Read data is registered and returned one cycle after grant; writes commit on the grant-cycle edge.

---
 rtl/fft_dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_fft_dmem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port FFT sample memory between the MCU (M0)
// and the butterfly engine (M1), with capped locked bursts and registered read return.
module fft_dmem_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;   // 1 = M1 was granted last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0, gnt1, cont;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;
  logic          unused_rd;

  assign unused_rd = ^mem_rd[31:DW];

  // Grants are gated by rst_n so an access cut by reset never reaches the RAM edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    cont = 1'b0;
    if (rst_n) begin
      if (owner_q == OWN_M0 && m0_req) begin
        if (!m1_req || cnt_q < CNT_LAST) begin
          gnt0 = 1'b1;
          cont = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (owner_q == OWN_M1 && m1_req) begin
        if (!m0_req || cnt_q < CNT_LAST) begin
          gnt1 = 1'b1;
          cont = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else if (m0_req && m1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (gnt0) begin
      mem_we = m0_we;
      mem_a  = 32'(m0_addr);
      mem_wd = 32'(m0_wdata);
    end else if (gnt1) begin
      mem_we = m1_we;
      mem_a  = 32'(m1_addr);
      mem_wd = 32'(m1_wdata);
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    last_d  = last_q;
    cnt_d   = '0;
    if (gnt0) begin
      owner_d = m0_lock ? OWN_M0 : OWN_NONE;
      last_d  = 1'b0;
    end else if (gnt1) begin
      owner_d = m1_lock ? OWN_M1 : OWN_NONE;
      last_d  = 1'b1;
    end
    // Counter saturates: it only sits at the cap while the other side is idle.
    if ((gnt0 || gnt1) && cont)
      cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= gnt0 && !m0_we;
      m1_rvalid_q <= gnt1 && !m1_we;
      if (gnt0 && !m0_we) m0_rdata_q <= mem_rd[DW-1:0];
      if (gnt1 && !m1_we) m1_rdata_q <= mem_rd[DW-1:0];
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_fft_dmem_arbiter.sv
// Randomized bench for fft_dmem_arbiter against a rule-level arbitration/memory model.
module tb_fft_dmem_arbiter;
  localparam int AW = 9, DW = 16, MAXB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [15:0] ram [0:255];

  fft_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_a[8:1]] <= mem_wd[15:0];
  assign mem_rd = {16'h0, ram[mem_a[8:1]]};

  int checks = 0, failures = 0;
  int mo_owner, mo_last, mo_cnt, last_g;
  logic [15:0] shadow [0:255];
  logic mo_rv0, mo_rv1;
  logic [15:0] mo_rd0, mo_rd1;
  // obs_pre = {m1_gnt, m0_gnt, mem_we, mem_a, mem_wd}; obs_post = {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}
  logic [66:0] obs_pre, exp_pre;
  logic [33:0] obs_post, exp_post;

  function automatic int model_pick();
    if (!rst_n) return -1;
    if (mo_owner == 0 && m0_req) return (m1_req && mo_cnt == MAXB - 1) ? 1 : 0;
    if (mo_owner == 1 && m1_req) return (m0_req && mo_cnt == MAXB - 1) ? 0 : 1;
    if (m0_req && m1_req) return 1 - mo_last;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  function automatic logic [66:0] bus_for(int g);
    if (g == 0) return {2'b01, m0_we, 32'(m0_addr), 16'h0, m0_wdata};
    if (g == 1) return {2'b10, m1_we, 32'(m1_addr), 16'h0, m1_wdata};
    return '0;
  endfunction

  task automatic model_reset();
    mo_owner = -1; mo_last = 1; mo_cnt = 0;
    mo_rv0 = 1'b0; mo_rv1 = 1'b0; mo_rd0 = '0; mo_rd1 = '0;
  endtask

  task automatic model_commit(input int g);
    mo_rv0 = 1'b0; mo_rv1 = 1'b0;
    if (g < 0) begin
      mo_owner = -1; mo_cnt = 0;
      return;
    end
    mo_cnt  = (mo_owner == g) ? ((mo_cnt + 1 > MAXB - 1) ? MAXB - 1 : mo_cnt + 1) : 0;
    mo_last = g;
    if (g == 0) begin
      mo_owner = m0_lock ? 0 : -1;
      if (m0_we) shadow[m0_addr[8:1]] = m0_wdata;
      else begin mo_rv0 = 1'b1; mo_rd0 = shadow[m0_addr[8:1]]; end
    end else begin
      mo_owner = m1_lock ? 1 : -1;
      if (m1_we) shadow[m1_addr[8:1]] = m1_wdata;
      else begin mo_rv1 = 1'b1; mo_rd1 = shadow[m1_addr[8:1]]; end
    end
  endtask

  // Enter right after a falling edge with inputs driven; leave at the next falling edge.
  task automatic step();
    #4;
    last_g  = model_pick();
    exp_pre = bus_for(last_g);
    obs_pre = {m1_gnt, m0_gnt, mem_we, mem_a, mem_wd};
    @(posedge clk);
    model_commit(last_g);
    #1;
    exp_post = {mo_rv1, mo_rv0, mo_rd1, mo_rd0};
    obs_post = {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata};
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1; m1_req = 1;
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if ({m1_gnt, m0_gnt, mem_we, mem_a, mem_wd} !== '0) begin
      failures++; $display("FAIL reset_bus got %h want 0", {m1_gnt, m0_gnt, mem_we, mem_a, mem_wd});
    end
    checks++;
    if ({m1_rvalid, m0_rvalid, m1_rdata, m0_rdata} !== '0) begin
      failures++; $display("FAIL reset_rdata got %h want 0", {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata});
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_read();
    ram[2] = 16'hABCD; shadow[2] = 16'hABCD;
    m0_req = 1; m0_we = 0; m0_addr = 9'h004;
    step();
    checks++;
    if (obs_pre !== {2'b01, 1'b0, 32'h4, 32'h0}) begin
      failures++; $display("FAIL t1_grant got %h want %h", obs_pre, {2'b01, 1'b0, 32'h4, 32'h0});
    end
    checks++;
    if ({obs_post[32], obs_post[15:0]} !== {1'b1, 16'hABCD}) begin
      failures++; $display("FAIL t1_rdata got %h want %h", {obs_post[32], obs_post[15:0]}, {1'b1, 16'hABCD});
    end
    idle_inputs();
    step();
    checks++;
    if ({obs_pre, obs_post} !== {exp_pre, exp_post} || obs_post[32] !== 1'b0) begin
      failures++; $display("FAIL t1_pulse got %h/%h want %h/%h", obs_pre, obs_post, exp_pre, exp_post);
    end
  endtask

  task automatic test_write_then_read();
    m1_req = 1; m1_we = 1; m1_addr = 9'h010; m1_wdata = 16'h1234;
    step();
    checks++;
    if (obs_pre !== {2'b10, 1'b1, 32'h10, 32'h1234} || obs_pre !== exp_pre) begin
      failures++; $display("FAIL t2_write got %h want %h", obs_pre, {2'b10, 1'b1, 32'h10, 32'h1234});
    end
    idle_inputs();
    m0_req = 1; m0_we = 0; m0_addr = 9'h010;
    step();
    checks++;
    if ({obs_post[32], obs_post[15:0]} !== {1'b1, 16'h1234}) begin
      failures++; $display("FAIL t2_readback got %h want %h", {obs_post[32], obs_post[15:0]}, {1'b1, 16'h1234});
    end
    idle_inputs();
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req = 1; m1_req = 1;
    m0_addr = AW'($urandom_range(0, 511)); m1_addr = AW'($urandom_range(0, 511));
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_pre[66:65] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || obs_pre !== exp_pre) begin
        failures++; $display("FAIL t3_alt cyc %0d got %h want %h", i, obs_pre, exp_pre);
      end
      checks++;
      if (obs_post[33:32] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || obs_post !== exp_post) begin
        failures++; $display("FAIL t3_rvalid cyc %0d got %h want %h", i, obs_post, exp_post);
      end
      if (obs_pre[65]) m0_addr = AW'($urandom_range(0, 511));
      if (obs_pre[66]) m1_addr = AW'($urandom_range(0, 511));
    end
    idle_inputs();
  endtask

  task automatic test_locked_burst();
    m0_req = 1; m0_addr = AW'($urandom_range(0, 511));
    step();
    m0_addr = AW'($urandom_range(0, 511));
    m1_req = 1; m1_lock = 1; m1_addr = AW'($urandom_range(0, 511));
    for (int i = 0; i < 40; i++) begin
      step();
      if (i < 18) begin
        checks++;
        if (obs_pre[66:65] !== ((i == 16) ? 2'b01 : 2'b10)) begin
          failures++; $display("FAIL t4_burst cyc %0d got %b want %b", i, obs_pre[66:65], (i == 16) ? 2'b01 : 2'b10);
        end
      end
      checks++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        failures++; $display("FAIL t4_model cyc %0d got %h/%h want %h/%h", i, obs_pre, obs_post, exp_pre, exp_post);
      end
      if (obs_pre[65]) m0_addr = AW'($urandom_range(0, 511));
      if (obs_pre[66]) m1_addr = AW'($urandom_range(0, 511));
    end
    idle_inputs();
    step();
  endtask

  task automatic test_burst_saturate();
    m1_req = 1; m1_lock = 1;
    for (int i = 0; i <= 30; i++) begin
      m1_we = 1'($urandom_range(0, 1)); m1_addr = AW'($urandom_range(0, 511)); m1_wdata = DW'($urandom);
      if (i == 30) begin m0_req = 1; m0_we = 0; m0_addr = AW'($urandom_range(0, 511)); end
      step();
      checks++;
      if (obs_pre[66:65] !== ((i == 30) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL t5_sat cyc %0d got %b want %b", i, obs_pre[66:65], (i == 30) ? 2'b01 : 2'b10);
      end
      checks++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        failures++; $display("FAIL t5_model cyc %0d got %h/%h want %h/%h", i, obs_pre, obs_post, exp_pre, exp_post);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] old;
    old = shadow[16];
    m0_req = 1; m0_we = 1; m0_addr = 9'h020; m0_wdata = ~old;
    #2;
    checks++;
    if ({m0_gnt, mem_we} !== 2'b11) begin
      failures++; $display("FAIL t6_pregrant got %b want 11", {m0_gnt, mem_we});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt, mem_we, m1_rvalid, m0_rvalid} !== 5'b0) begin
      failures++; $display("FAIL t6_cut got %b want 00000", {m1_gnt, m0_gnt, mem_we, m1_rvalid, m0_rvalid});
    end
    @(posedge clk);
    #1;
    checks++;
    if (ram[16] !== old) begin
      failures++; $display("FAIL t6_ram got %h want %h", ram[16], old);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    m0_req = 1; m0_addr = 9'h020; m1_req = 1; m1_addr = AW'($urandom_range(0, 511));
    step();
    checks++;
    if (obs_pre[66:65] !== 2'b01 || {obs_pre, obs_post} !== {exp_pre, exp_post} || obs_post[15:0] !== old) begin
      failures++; $display("FAIL t6_after got %h/%h want %h/%h", obs_pre, obs_post, exp_pre, exp_post);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; m0_we = 1'($urandom_range(0, 1));
        m0_addr = AW'($urandom_range(0, 63)); m0_wdata = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; m1_we = 1'($urandom_range(0, 1));
        m1_addr = AW'($urandom_range(0, 63)); m1_wdata = DW'($urandom);
      end
      m0_req = p0; m1_req = p1;
      m0_lock = ($urandom_range(0, 3) == 0); m1_lock = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if ({obs_pre, obs_post} !== {exp_pre, exp_post}) begin
        failures++; $display("FAIL rnd cyc %0d got %h/%h want %h/%h", i, obs_pre, obs_post, exp_pre, exp_post);
      end
      if (obs_pre[65]) p0 = 0;
      if (obs_pre[66]) p1 = 0;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
      shadow[i] = ram[i];
    end
    model_reset();
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_then_read();
    test_alternate();
    test_locked_burst();
    test_burst_saturate();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
